// File: rtl/bpredict_history_store.sv
// State holder for the perceptron branch predictor: global history register, weight table
// and pending-branch count, committed from the prediction stage's results each accepted cycle.
module bpredict_history_store #(
  parameter int GHR_DEPTH = 20,
  parameter int WT_ROWS   = 228,
  parameter int WT_ROW_W  = 72
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_fetchValid_1,
  input  logic [131:0]                    i_newGHREntry_132,
  input  logic [2:0]                      i_passBNum_3,
  input  logic [7:0]                      i_errWeightPos_8,
  input  logic [WT_ROW_W-1:0]             i_newWeights_72,
  input  logic [4:0]                      i_errGhrIdx_5,
  input  logic [3:0]                      i_newPendingB_4,
  output logic                            o_ready_1,
  output logic [GHR_DEPTH*33-1:0]         o_globalHistoryRegister_660,
  output logic [WT_ROWS*WT_ROW_W-1:0]     o_weightTable_16416,
  output logic [7:0]                      o_pendingB_8,
  output logic [2:0]                      o_counter_3
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [2:0] ERR_CODE = 3'b111;

  state_t               state;
  state_t               state_next;
  logic [7:0]           init_idx;
  logic [32:0]          ghr      [GHR_DEPTH];
  logic [32:0]          ghr_next [GHR_DEPTH];
  logic [32:0]          new_entry [4];
  logic [WT_ROW_W-1:0]  wt       [WT_ROWS];
  logic [7:0]           pending;
  logic [2:0]           counter;
  logic [2:0]           counter_next;
  logic                 accept;

  assign accept = o_ready_1 && i_fetchValid_1;

  // State register and INIT row pointer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) init_idx <= init_idx + 8'd1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == ST_INIT && init_idx == 8'(WT_ROWS - 1)) state_next = ST_RUN;
  end

  always_comb begin
    o_ready_1 = (state == ST_RUN);
  end

  always_comb begin
    for (int k = 0; k < 4; k++) new_entry[k] = i_newGHREntry_132[k*33 +: 33];
  end

  // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic [4:0] src;
    src          = '0;
    counter_next = counter;
    for (int j = 0; j < GHR_DEPTH; j++) ghr_next[j] = ghr[j];
    if (accept) begin
      if (i_passBNum_3 <= 3'd4) begin
        counter_next = i_passBNum_3;
        for (int j = 0; j < GHR_DEPTH; j++) begin
          src = 5'(j) - {2'b00, i_passBNum_3};
          if (j < int'(i_passBNum_3)) ghr_next[j] = new_entry[2'(j)];
          else                        ghr_next[j] = ghr[src];
        end
      end else if (i_passBNum_3 == ERR_CODE) begin
        counter_next = '0;
        if (int'(i_errGhrIdx_5) < GHR_DEPTH) begin
          // Flip the taken bit of the mispredicted branch and make it the youngest entry.
          for (int j = 0; j < GHR_DEPTH; j++) begin
            src = 5'(j) + i_errGhrIdx_5;
            if (j == 0)
              ghr_next[j] = {ghr[i_errGhrIdx_5][32:1], ~ghr[i_errGhrIdx_5][0]};
            else if (j + int'(i_errGhrIdx_5) < GHR_DEPTH)
              ghr_next[j] = ghr[src];
            else
              ghr_next[j] = '0;
          end
        end
      end else begin
        counter_next = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int j = 0; j < GHR_DEPTH; j++) ghr[j] <= '0;
      pending <= '0;
      counter <= '0;
    end else begin
      for (int j = 0; j < GHR_DEPTH; j++) ghr[j] <= ghr_next[j];
      counter <= counter_next;
      if (accept) pending <= {4'b0000, i_newPendingB_4};
    end
  end

  // NOTE: the weight array has no reset branch; it is cleared row by row during INIT instead.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (state == ST_INIT)
        wt[init_idx] <= '0;
      else if (accept && i_errWeightPos_8 < 8'(WT_ROWS))
        wt[i_errWeightPos_8] <= i_newWeights_72;
    end
  end

  for (genvar g = 0; g < GHR_DEPTH; g++) begin : g_ghr_out
    assign o_globalHistoryRegister_660[g*33 +: 33] = ghr[g];
  end

  for (genvar r = 0; r < WT_ROWS; r++) begin : g_wt_out
    assign o_weightTable_16416[r*WT_ROW_W +: WT_ROW_W] = wt[r];
  end

  assign o_pendingB_8 = pending;
  assign o_counter_3  = counter;

endmodule

// File: tb/tb_bpredict_history_store.sv
// Directed self-checking bench for bpredict_history_store: INIT sweep, push, error
// rewind, retrain, gating by fetch-valid, illegal codes and mid-RUN reset.
module tb_bpredict_history_store;

  logic           clk;
  logic           rst_n;
  logic           fetch_valid;
  logic [131:0]   new_ghr;
  logic [2:0]     pass_n;
  logic [7:0]     err_pos;
  logic [71:0]    new_w;
  logic [4:0]     err_idx;
  logic [3:0]     new_pend;
  logic           ready;
  logic [659:0]   ghr_flat;
  logic [16415:0] wt_flat;
  logic [7:0]     pending;
  logic [2:0]     counter;

  int errors = 0;
  int checks = 0;

  bpredict_history_store dut (
    .i_clk                       (clk),
    .i_rst_n                     (rst_n),
    .i_fetchValid_1              (fetch_valid),
    .i_newGHREntry_132           (new_ghr),
    .i_passBNum_3                (pass_n),
    .i_errWeightPos_8            (err_pos),
    .i_newWeights_72             (new_w),
    .i_errGhrIdx_5               (err_idx),
    .i_newPendingB_4             (new_pend),
    .o_ready_1                   (ready),
    .o_globalHistoryRegister_660 (ghr_flat),
    .o_weightTable_16416         (wt_flat),
    .o_pendingB_8                (pending),
    .o_counter_3                 (counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] ghr_at(input int j);
    return ghr_flat[j*33 +: 33];
  endfunction

  function automatic logic [71:0] row_at(input int r);
    return wt_flat[r*72 +: 72];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic v, input logic [2:0] n,
                      input logic [32:0] e0, input logic [32:0] e1,
                      input logic [32:0] e2, input logic [32:0] e3,
                      input logic [7:0] wpos, input logic [71:0] w,
                      input logic [4:0] eidx, input logic [3:0] pend);
    fetch_valid = v;
    pass_n      = n;
    new_ghr     = {e3, e2, e1, e0};
    err_pos     = wpos;
    new_w       = w;
    err_idx     = eidx;
    new_pend    = pend;
    step();
    fetch_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int cnt;
    cnt = 0;
    while (!ready && cnt < 400) begin
      step();
      cnt++;
    end
    check(tag, 72'(cnt), 72'd228);
  endtask

  task automatic check_rows(input string tag, input int skip);
    logic [71:0] acc;
    acc = '0;
    for (int r = 0; r < 228; r++) if (r != skip) acc = acc | row_at(r);
    check(tag, acc, 72'h0);
  endtask

  task automatic check_ghr_zero(input string tag);
    logic [32:0] acc;
    acc = '0;
    for (int j = 0; j < 20; j++) acc = acc | ghr_at(j);
    check(tag, 72'(acc), 72'h0);
  endtask

  localparam logic [71:0] W1 = 72'hA5_A501_0203_0405_0607;

  initial begin
    logic [32:0] exp_e;
    int jj;
    rst_n = 1'b0; fetch_valid = 1'b0; new_ghr = '0; pass_n = '0;
    err_pos = 8'hFF; new_w = '0; err_idx = '0; new_pend = '0;
    step(); step();
    check("rst_ready", 72'(ready), 72'h0);
    check("rst_pend", 72'(pending), 72'h0);
    check("rst_cnt", 72'(counter), 72'h0);
    check_ghr_zero("rst_ghr");

    // Traffic presented during INIT must be ignored.
    fetch_valid = 1'b1; pass_n = 3'd1; new_ghr = {99'h0, 33'h1FF};
    err_pos = 8'd5; new_w = '1; new_pend = 4'hF;
    rst_n = 1'b1;
    wait_ready("init_len");
    fetch_valid = 1'b0;
    check_ghr_zero("init_ghr");
    check("init_pend", 72'(pending), 72'h0);
    check_rows("init_rows", -1);

    xact(1, 3'd1, 33'hAB, 0, 0, 0, 8'hFF, 0, 0, 4'h3);
    check("p1_g0", 72'(ghr_at(0)), 72'hAB);
    check("p1_cnt", 72'(counter), 72'd1);
    check("p1_pend", 72'(pending), 72'h03);

    xact(1, 3'd2, 33'h201, 33'h208, 0, 0, 8'hFF, 0, 0, 4'h9);
    check("p2_g0", 72'(ghr_at(0)), 72'h201);
    check("p2_g1", 72'(ghr_at(1)), 72'h208);
    check("p2_g2", 72'(ghr_at(2)), 72'hAB);
    check("p2_cnt", 72'(counter), 72'd2);
    check("p2_pend", 72'(pending), 72'h09);

    // Fill with 20 distinct entries, then push four more.
    for (int p = 0; p < 5; p++)
      xact(1, 3'd4, 33'h1000 + 33'(p*4), 33'h1001 + 33'(p*4), 33'h1002 + 33'(p*4),
           33'h1003 + 33'(p*4), 8'hFF, 0, 0, 4'h0);
    xact(1, 3'd4, 33'h2000, 33'h2001, 33'h2002, 33'h2003, 8'hFF, 0, 0, 4'h0);
    for (int j = 0; j < 20; j++) begin
      if (j < 4) exp_e = 33'h2000 + 33'(j);
      else begin
        jj = j - 4;
        exp_e = 33'h1000 + 33'((4 - jj / 4) * 4 + jj % 4);
      end
      check($sformatf("full_g%0d", j), 72'(ghr_at(j)), 72'(exp_e));
    end
    check("full_cnt", 72'(counter), 72'd4);

    xact(1, 3'd4, 33'h3000, 33'h3001, 33'h3002, 33'h81, 8'hFF, 0, 0, 4'h0);
    check("pre_err_g3", 72'(ghr_at(3)), 72'h81);

    xact(1, 3'b111, 0, 0, 0, 0, 8'd17, W1, 5'd3, 4'h5);
    check("err_g0", 72'(ghr_at(0)), 72'h80);
    check("err_g1", 72'(ghr_at(1)), 72'h2000);
    check("err_g2", 72'(ghr_at(2)), 72'h2001);
    check("err_g16", 72'(ghr_at(16)), 72'h100B);
    check("err_g17", 72'(ghr_at(17)), 72'h0);
    check("err_g19", 72'(ghr_at(19)), 72'h0);
    check("err_row17", row_at(17), W1);
    check("err_cnt", 72'(counter), 72'd0);
    check("err_pend", 72'(pending), 72'h05);

    xact(0, 3'd1, 33'h555, 0, 0, 0, 8'd17, ~W1, 0, 4'hC);
    check("nv_g0", 72'(ghr_at(0)), 72'h80);
    check("nv_g1", 72'(ghr_at(1)), 72'h2000);
    check("nv_row17", row_at(17), W1);
    check("nv_pend", 72'(pending), 72'h05);

    xact(1, 3'd0, 33'h1, 0, 0, 0, 8'd230, ~W1, 0, 4'h0);
    check("oor_g0", 72'(ghr_at(0)), 72'h80);
    check("oor_cnt", 72'(counter), 72'd0);
    check("oor_row17", row_at(17), W1);
    check_rows("oor_rows", 17);

    xact(1, 3'd1, 33'h77, 0, 0, 0, 8'hFF, 0, 0, 4'h0);
    check("p3_g1", 72'(ghr_at(1)), 72'h80);
    check("p3_cnt", 72'(counter), 72'd1);
    xact(1, 3'd5, 33'h99, 33'h98, 0, 0, 8'hFF, 0, 0, 4'h0);
    check("ill_g0", 72'(ghr_at(0)), 72'h77);
    check("ill_cnt", 72'(counter), 72'd0);
    xact(1, 3'd1, 33'h66, 0, 0, 0, 8'hFF, 0, 0, 4'h0);
    check("p4_cnt", 72'(counter), 72'd1);
    xact(1, 3'b111, 0, 0, 0, 0, 8'hFF, 0, 5'd21, 4'h6);
    check("bigidx_g0", 72'(ghr_at(0)), 72'h66);
    check("bigidx_g1", 72'(ghr_at(1)), 72'h77);
    check("bigidx_cnt", 72'(counter), 72'd0);
    check("bigidx_pend", 72'(pending), 72'h06);

    // One-cycle reset in RUN, five cycles after the last accepted cycle.
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    check("rr_ready", 72'(ready), 72'h0);
    check("rr_pend", 72'(pending), 72'h0);
    check_ghr_zero("rr_ghr");
    rst_n = 1'b1;
    wait_ready("rr_init_len");
    check_rows("rr_rows", -1);
    check_ghr_zero("rr_ghr_run");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bpredict_history_store.md
# bpredict_history_store

Sequential state holder for the perceptron branch predictor in the instruction-fetch path. It holds the 20-entry global history register (GHR), the 228-entry weight table and the pending-branch count, and feeds all three to the combinational prediction/learning stage every cycle. It commits that stage's results on the next clock edge: new GHR entries, the corrected history bit and the retrained weight row. After reset it clears the weight table one row per cycle before it accepts any traffic.

## Interface
- GHR_DEPTH, 20, number of GHR entries; each entry is 33 bits.
- WT_ROWS, 228, number of weight-table rows.
- WT_ROW_W, 72, width of one row: nine signed 8-bit weights; weight 8 is the bias.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_fetchValid_1  in  1  the prediction stage's outputs are valid this cycle.
- i_newGHREntry_132  in  132  four 33-bit candidate entries. Entry k is at [k*33+:33]; bit 0 is the taken bit, bits 32:1 are the branch address.
- i_passBNum_3  in  3  number of entries to push, 0..4. Value 3'b111 marks an error cycle; 5 and 6 are illegal.
- i_errWeightPos_8  in  8  row to retrain. 8'hFF means no retrain.
- i_newWeights_72  in  72  replacement weight row.
- i_errGhrIdx_5  in  5  GHR index of the mispredicted branch. Used only when i_passBNum_3 == 3'b111.
- i_newPendingB_4  in  4  pending-B count produced by the prediction stage.
- o_ready_1  out  1  high in RUN state.
- o_globalHistoryRegister_660  out  660  GHR; entry j at [j*33+:33]. Entry 0 is the youngest.
- o_weightTable_16416  out  16416  weight table; row r at [r*72+:72].
- o_pendingB_8  out  8  registered pending-B count.
- o_counter_3  out  3  number of entries pushed by the last accepted cycle.

## Operation
- FSM states:
  - INIT: on reset, initIdx=0. Each cycle writes row initIdx to zero and increments initIdx. When initIdx==227 is written, the FSM moves to RUN. All i_* update inputs are ignored in INIT.
  - RUN: stays in RUN until reset.
- A cycle is accepted when o_ready_1 && i_fetchValid_1. Nothing changes on a non-accepted cycle.
- Push (accepted, i_passBNum_3=n, 0≤n≤4):
  - GHR[j+n] <= GHR[j] for j+n<20; entries pushed past index 19 are dropped.
  - GHR[k] <= i_newGHREntry_132 entry k, for k<n.
  - n=0 leaves the GHR unchanged.
- Error (accepted, i_passBNum_3==3'b111, idx=i_errGhrIdx_5):
  - Let e = GHR[idx]. Entries 0..idx-1 are discarded: GHR[j] <= GHR[j+idx] for j+idx<20.
  - GHR[0] <= {e[32:1], ~e[0]}.
  - Vacated top slots are zeroed.
  - idx≥20 makes the GHR update a no-op.
- Illegal i_passBNum_3 values 5 and 6: GHR unchanged, o_counter_3 <= 0.
- Retrain (accepted, i_errWeightPos_8 < 228):
  - row[i_errWeightPos_8] <= i_newWeights_72.
  - Values 228..255, including 8'hFF, write nothing.
  - Retrain is independent of push/error; both may occur in the same cycle.
- Pending count (accepted): o_pendingB_8 <= zero-extended i_newPendingB_4.
- o_counter_3 (accepted):
  - <= n on a push;
  - <= 0 on an error.
- Weights are stored verbatim. The prediction stage owns the arithmetic and any saturation.

## Timing
- Reset values: o_ready_1=0, GHR all zero, o_pendingB_8=0, o_counter_3=0, FSM=INIT, initIdx=0. The weight array is not cleared by reset itself; INIT clears it.
- INIT lasts exactly 228 cycles after i_rst_n is released. o_ready_1 rises on cycle 229, with all rows zero by then.
- Every update is visible on outputs the cycle after the accepting edge. There is no combinational path from inputs to outputs.
- Reset asserted mid-RUN or mid-INIT: on the next edge the FSM returns to INIT, initIdx=0, and the GHR and counters are zeroed. INIT then restarts from row 0.
- A retrain to the row currently being read is seen by the predictor one cycle later. The predictor must not assume a bypass.

## Test plan
- Reset release -> o_ready_1=0 for 228 cycles, then 1. All 228 rows read 72'h0. GHR=0 and o_pendingB_8=0 throughout.
- RUN, push n=2 with entries {addr=0x100,t=1},{addr=0x104,t=0} -> next cycle GHR[0]=0x201, GHR[1]=0x208, old GHR[0] now at index 2, o_counter_3=2.
- GHR full (20 distinct entries), push n=4 -> old entries 16..19 dropped, old entry 15 now at index 19.
- Error with idx=3 where GHR[3]={0x40,t=1} and i_errWeightPos_8=17 -> GHR[0]={0x40,t=0}, GHR[1]=old GHR[4], GHR[17..19]=0, row17=i_newWeights_72, o_counter_3=0.
- i_fetchValid_1=0 with a push and a retrain presented -> no state change. Separately, i_errWeightPos_8=230 -> no row written.
- Assert i_rst_n=0 for one cycle in RUN, 5 cycles after a push -> GHR zeroed, o_ready_1 low again for 228 cycles, rows re-cleared.
